// File: rtl/wave_classify_ctrl.sv
// -----------------------------------------------------------------------------
// wave_classify_ctrl
//   Measurement sequencer for the waveform distinguisher path. It generates a
//   fixed-length measurement window from clk, synchronises the raw comparator
//   output and time-stamps the first rising edge in each window. That phase is
//   classified into sine / iso-triangle / square / jag bands. A class is
//   committed to sel_sig only after CONFIRM consecutive agreeing windows.
//   Loss of signal is flagged after TIMEOUT_WIN consecutive edgeless windows.
//
// Ports
//   clk        in   system clock (1 MHz)
//   rst_n      in   synchronous active-low reset
//   en         in   measurement enable
//   cmp1_sig   in   raw comparator output, asynchronous to clk
//   win_set    out  one-cycle pulse in the cycle where win_cnt == WINDOW-1
//   win_cnt    out  current phase counter value
//   phase_q    out  phase captured in the last completed window (0 if none)
//   cand_sig   out  candidate class of the last completed window (one-hot/0)
//   sel_sig    out  committed class: 0001 sine, 0010 iso, 0100 square, 1000 jag
//   valid      out  sel_sig holds a committed class
//   no_signal  out  timeout flag
// -----------------------------------------------------------------------------
module wave_classify_ctrl #(
  parameter int WINDOW      = 1000,
  parameter int CNT_W       = 10,
  parameter int CONFIRM     = 3,
  parameter int TIMEOUT_WIN = 4,
  parameter int SIN_MAX     = 120,
  parameter int ISO_LO      = 380,
  parameter int ISO_HI      = 420,
  parameter int SQR_LO      = 490,
  parameter int SQR_HI      = 510,
  parameter int JAG_LO      = 690,
  parameter int JAG_HI      = 720
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cmp1_sig,
  output logic             win_set,
  output logic [CNT_W-1:0] win_cnt,
  output logic [CNT_W-1:0] phase_q,
  output logic [3:0]       cand_sig,
  output logic [3:0]       sel_sig,
  output logic             valid,
  output logic             no_signal
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_EVAL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] SIN_MAX_V = CNT_W'(SIN_MAX);
  localparam logic [CNT_W-1:0] ISO_LO_V  = CNT_W'(ISO_LO);
  localparam logic [CNT_W-1:0] ISO_HI_V  = CNT_W'(ISO_HI);
  localparam logic [CNT_W-1:0] SQR_LO_V  = CNT_W'(SQR_LO);
  localparam logic [CNT_W-1:0] SQR_HI_V  = CNT_W'(SQR_HI);
  localparam logic [CNT_W-1:0] JAG_LO_V  = CNT_W'(JAG_LO);
  localparam logic [CNT_W-1:0] JAG_HI_V  = CNT_W'(JAG_HI);
  localparam logic [2:0]       CONFIRM_V = 3'(CONFIRM);
  localparam logic [3:0]       TIMEOUT_V = 4'(TIMEOUT_WIN);

  // Inclusive band membership test used by the classifier.
  function automatic logic in_band(input logic [CNT_W-1:0] v,
                                   input logic [CNT_W-1:0] lo,
                                   input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  state_t           state_r, state_next_s;
  logic             s1_r, s2_r, s3_r;
  logic             edge_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic             win_set_r;
  logic             got_r, ev_got_r;
  logic [CNT_W-1:0] ph_r, ev_ph_r;
  logic [3:0]       cand_s, prev_cand_r;
  logic [2:0]       match_r, match_next_s;
  logic [3:0]       miss_r, miss_next_s;
  logic [3:0]       sel_r, sel_next_s, cand_r;
  logic             valid_r, valid_next_s;
  logic             nosig_r, nosig_next_s;
  logic [CNT_W-1:0] phase_q_r;

  // s3 delays the synchronised level so that edge_s marks a single rising edge.
  assign edge_s = s2_r & ~s3_r;

  // Two-flop synchroniser plus edge-detect delay flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= cmp1_sig;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // Next phase counter value: held at 0 while disabled, wraps at WINDOW-1.
  always_comb begin
    cnt_next_s = cnt_r;
    if (!en) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else if (cnt_r == WIN_LAST) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else begin
      cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Sequencer next state; dropping en abandons any pending evaluation.
  always_comb begin
    state_next_s = state_r;
    if (!en) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_next_s = ST_RUN;
        ST_RUN: begin
          if (cnt_r == WIN_LAST) begin
            state_next_s = ST_EVAL;
          end else begin
            state_next_s = ST_RUN;
          end
        end
        ST_EVAL: state_next_s = ST_RUN;
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // State, phase counter and registered window pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      win_set_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      win_set_r <= (cnt_next_s == WIN_LAST);
    end
  end

  // First-edge capture and end-of-window snapshot. An edge in the last cycle
  // is folded into the snapshot; one in cycle 0 lands in the new window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      got_r    <= 1'b0;
      ph_r     <= {CNT_W{1'b0}};
      ev_got_r <= 1'b0;
      ev_ph_r  <= {CNT_W{1'b0}};
    end else if (!en) begin
      got_r <= 1'b0;
      ph_r  <= {CNT_W{1'b0}};
    end else if ((state_r == ST_RUN) && (cnt_r == WIN_LAST)) begin
      ev_got_r <= got_r | edge_s;
      ev_ph_r  <= got_r ? ph_r : (edge_s ? cnt_r : {CNT_W{1'b0}});
      got_r    <= 1'b0;
      ph_r     <= {CNT_W{1'b0}};
    end else if (edge_s && !got_r) begin
      got_r <= 1'b1;
      ph_r  <= cnt_r;
    end
  end

  // Band classifier on the snapshot; first match wins in sine/iso/sqr/jag order.
  always_comb begin
    cand_s = 4'b0000;
    if (!ev_got_r) begin
      cand_s = 4'b0000;
    end else if (ev_ph_r <= SIN_MAX_V) begin
      cand_s = 4'b0001;
    end else if (in_band(ev_ph_r, ISO_LO_V, ISO_HI_V)) begin
      cand_s = 4'b0010;
    end else if (in_band(ev_ph_r, SQR_LO_V, SQR_HI_V)) begin
      cand_s = 4'b0100;
    end else if (in_band(ev_ph_r, JAG_LO_V, JAG_HI_V)) begin
      cand_s = 4'b1000;
    end else begin
      cand_s = 4'b0000;
    end
  end

  // Confirmation / timeout decision computed from the current snapshot.
  always_comb begin
    match_next_s = match_r;
    miss_next_s  = miss_r;
    sel_next_s   = sel_r;
    valid_next_s = valid_r;
    nosig_next_s = nosig_r;
    if (!ev_got_r) begin
      match_next_s = 3'd0;
      if (miss_r >= TIMEOUT_V) begin
        miss_next_s = TIMEOUT_V;
      end else begin
        miss_next_s = miss_r + 4'd1;
      end
      if (miss_next_s == TIMEOUT_V) begin
        nosig_next_s = 1'b1;
        sel_next_s   = 4'b0000;
        valid_next_s = 1'b0;
      end else begin
        nosig_next_s = nosig_r;
      end
    end else begin
      miss_next_s  = 4'd0;
      nosig_next_s = 1'b0;
      if (cand_s == 4'b0000) begin
        match_next_s = 3'd0;
      end else if (cand_s == prev_cand_r) begin
        if (match_r >= CONFIRM_V) begin
          match_next_s = CONFIRM_V;
        end else begin
          match_next_s = match_r + 3'd1;
        end
      end else begin
        match_next_s = 3'd1;
      end
      // A zero match count never commits because CONFIRM is at least 1.
      if (match_next_s >= CONFIRM_V) begin
        sel_next_s   = cand_s;
        valid_next_s = 1'b1;
      end else begin
        sel_next_s   = sel_r;
      end
    end
  end

  // Decision registers: updated only at the end of EVAL; outputs hold in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match_r     <= 3'd0;
      miss_r      <= 4'd0;
      prev_cand_r <= 4'b0000;
      sel_r       <= 4'b0000;
      cand_r      <= 4'b0000;
      valid_r     <= 1'b0;
      nosig_r     <= 1'b0;
      phase_q_r   <= {CNT_W{1'b0}};
    end else if (!en) begin
      match_r     <= 3'd0;
      miss_r      <= 4'd0;
      prev_cand_r <= 4'b0000;
    end else if (state_r == ST_EVAL) begin
      match_r     <= match_next_s;
      miss_r      <= miss_next_s;
      prev_cand_r <= cand_s;
      sel_r       <= sel_next_s;
      cand_r      <= cand_s;
      valid_r     <= valid_next_s;
      nosig_r     <= nosig_next_s;
      phase_q_r   <= ev_ph_r;
    end
  end

  assign win_set   = win_set_r;
  assign win_cnt   = cnt_r;
  assign phase_q   = phase_q_r;
  assign cand_sig  = cand_r;
  assign sel_sig   = sel_r;
  assign valid     = valid_r;
  assign no_signal = nosig_r;

endmodule

// File: tb/tb_wave_classify_ctrl.sv
`timescale 1ns/1ps
module tb_wave_classify_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       cmp1_sig = 1'b0;
  logic       win_set;
  logic [9:0] win_cnt;
  logic [9:0] phase_q;
  logic [3:0] cand_sig;
  logic [3:0] sel_sig;
  logic       valid;
  logic       no_signal;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] cand;
    logic [31:0] ph;
    logic [31:0] sel;
    logic [31:0] vld;
    logic [31:0] ns;
    string       tag;
  } exp_t;

  exp_t exp_q[$];

  wave_classify_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cmp1_sig(cmp1_sig),
    .win_set(win_set), .win_cnt(win_cnt), .phase_q(phase_q),
    .cand_sig(cand_sig), .sel_sig(sel_sig), .valid(valid),
    .no_signal(no_signal)
  );

  always #500 clk = ~clk;

  initial begin
    #100_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Raw comparator high for samples P-2..P so that the edge pulse lands at P.
  function automatic logic in_pulse(input int c, input int p);
    if (p < 0) return 1'b0;
    return ((c - p + 2 + 1000) % 1000) < 3;
  endfunction

  task automatic wait_cnt(input int target);
    int k = 0;
    while (int'(win_cnt) != target && k < 2100) begin
      tick();
      k++;
    end
    check("wait_cnt", 32'(win_cnt), 32'(target));
  endtask

  // Entry: sampled win_cnt == 2. Drives one window, then compares its result
  // when the DUT presents it at win_cnt == 1 of the following window.
  task automatic run_window(input int pa, input int pb, input logic [3:0] cand,
                            input int ph, input logic [3:0] sel, input logic v,
                            input logic ns, input string tag);
    exp_t e;
    e.cand = 32'(cand); e.ph = 32'(ph); e.sel = 32'(sel);
    e.vld = 32'(v); e.ns = 32'(ns); e.tag = tag;
    exp_q.push_back(e);
    for (int i = 0; i < 1000; i++) begin
      int c;
      c = int'(win_cnt);
      if (c == 1 && exp_q.size() > 0) begin
        exp_t r;
        r = exp_q.pop_front();
        check({r.tag, ".cand"},  32'(cand_sig),  r.cand);
        check({r.tag, ".phase"}, 32'(phase_q),   r.ph);
        check({r.tag, ".sel"},   32'(sel_sig),   r.sel);
        check({r.tag, ".valid"}, 32'(valid),     r.vld);
        check({r.tag, ".nosig"}, 32'(no_signal), r.ns);
      end
      cmp1_sig = in_pulse(c, pa) || in_pulse(c, pb);
      tick();
    end
    check({tag, ".drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int bad_set;
    int bad_cnt;
    // Reset held with en high and the comparator toggling.
    rst_n = 1'b0;
    en    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cmp1_sig = ~cmp1_sig;
      tick();
    end
    check("rst.win_set", 32'(win_set),   32'd0);
    check("rst.win_cnt", 32'(win_cnt),   32'd0);
    check("rst.phase_q", 32'(phase_q),   32'd0);
    check("rst.cand",    32'(cand_sig),  32'd0);
    check("rst.sel",     32'(sel_sig),   32'd0);
    check("rst.valid",   32'(valid),     32'd0);
    check("rst.nosig",   32'(no_signal), 32'd0);

    // Release: this cycle is the first enabled one, at win_cnt = 0.
    rst_n    = 1'b1;
    cmp1_sig = 1'b0;
    bad_set  = 0;
    bad_cnt  = 0;
    for (int k = 0; k < 2000; k++) begin
      if (win_set !== ((k % 1000) == 999)) bad_set++;
      if (int'(win_cnt) != (k % 1000)) bad_cnt++;
      tick();
    end
    check("win_set.pattern", 32'(bad_set), 32'd0);
    check("win_cnt.pattern", 32'(bad_cnt), 32'd0);

    wait_cnt(2);
    // Square commit after three agreeing windows.
    run_window(500, -1, 4'b0100, 500, 4'b0000, 1'b0, 1'b0, "sqr1");
    run_window(500, -1, 4'b0100, 500, 4'b0000, 1'b0, 1'b0, "sqr2");
    run_window(500, -1, 4'b0100, 500, 4'b0100, 1'b1, 1'b0, "sqr3");
    // Sine commit, iso glitch, then jag takes over.
    run_window(50,  -1, 4'b0001, 50,  4'b0100, 1'b1, 1'b0, "sin1");
    run_window(50,  -1, 4'b0001, 50,  4'b0100, 1'b1, 1'b0, "sin2");
    run_window(50,  -1, 4'b0001, 50,  4'b0001, 1'b1, 1'b0, "sin3");
    run_window(400, -1, 4'b0010, 400, 4'b0001, 1'b1, 1'b0, "iso_glitch");
    run_window(700, -1, 4'b1000, 700, 4'b0001, 1'b1, 1'b0, "jag1");
    run_window(700, -1, 4'b1000, 700, 4'b0001, 1'b1, 1'b0, "jag2");
    run_window(700, -1, 4'b1000, 700, 4'b1000, 1'b1, 1'b0, "jag3");
    // Band boundaries; none reaches CONFIRM so sel stays jag.
    run_window(120, -1, 4'b0001, 120, 4'b1000, 1'b1, 1'b0, "b120");
    run_window(121, -1, 4'b0000, 121, 4'b1000, 1'b1, 1'b0, "b121");
    run_window(380, -1, 4'b0010, 380, 4'b1000, 1'b1, 1'b0, "b380");
    run_window(379, -1, 4'b0000, 379, 4'b1000, 1'b1, 1'b0, "b379");
    run_window(510, -1, 4'b0100, 510, 4'b1000, 1'b1, 1'b0, "b510");
    run_window(511, -1, 4'b0000, 511, 4'b1000, 1'b1, 1'b0, "b511");
    run_window(720, -1, 4'b1000, 720, 4'b1000, 1'b1, 1'b0, "b720");
    run_window(721, -1, 4'b0000, 721, 4'b1000, 1'b1, 1'b0, "b721");
    run_window(999, -1, 4'b0000, 999, 4'b1000, 1'b1, 1'b0, "b999");
    // Edge in cycle 0 belongs to the following window.
    run_window(0,   -1, 4'b0000, 0,   4'b1000, 1'b1, 1'b0, "b0_prev");
    run_window(-1,  -1, 4'b0001, 0,   4'b1000, 1'b1, 1'b0, "b0_next");
    // Only the first edge counts.
    run_window(60, 505, 4'b0001, 60,  4'b1000, 1'b1, 1'b0, "multi");
    // Timeout after four edgeless windows.
    run_window(-1,  -1, 4'b0000, 0,   4'b1000, 1'b1, 1'b0, "miss1");
    run_window(-1,  -1, 4'b0000, 0,   4'b1000, 1'b1, 1'b0, "miss2");
    run_window(-1,  -1, 4'b0000, 0,   4'b1000, 1'b1, 1'b0, "miss3");
    run_window(-1,  -1, 4'b0000, 0,   4'b0000, 1'b0, 1'b1, "miss4");
    run_window(60,  -1, 4'b0001, 60,  4'b0000, 1'b0, 1'b0, "recover1");
    run_window(60,  -1, 4'b0001, 60,  4'b0000, 1'b0, 1'b0, "recover2");
    run_window(60,  -1, 4'b0001, 60,  4'b0001, 1'b1, 1'b0, "recover3");

    // Enable dropped mid-window.
    wait_cnt(600);
    en = 1'b0;
    tick();
    check("en_off.win_cnt", 32'(win_cnt), 32'd0);
    check("en_off.sel",     32'(sel_sig), 32'd1);
    check("en_off.valid",   32'(valid),   32'd1);
    check("en_off.win_set", 32'(win_set), 32'd0);
    tick(); tick(); tick();
    check("en_off.hold_cnt", 32'(win_cnt), 32'd0);
    check("en_off.hold_sel", 32'(sel_sig), 32'd1);
    en = 1'b1;
    tick();
    check("en_on.win_cnt", 32'(win_cnt), 32'd1);

    // Reset mid-window.
    wait_cnt(300);
    rst_n = 1'b0;
    tick();
    check("rst2.sel",     32'(sel_sig),   32'd0);
    check("rst2.valid",   32'(valid),     32'd0);
    check("rst2.win_cnt", 32'(win_cnt),   32'd0);
    check("rst2.cand",    32'(cand_sig),  32'd0);
    check("rst2.phase_q", 32'(phase_q),   32'd0);
    check("rst2.nosig",   32'(no_signal), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst2.restart", 32'(win_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
